// File: rtl/sdcard_spi_responder.sv
// ---------------------------------------------------------------------------
// sdcard_spi_responder
//
// Card end of an SPI-mode SD link. It decodes 48-bit command frames from the
// host, answers with R1/R3/R7 responses, and serves single-block reads
// (CMD17) and writes (CMD24) from an external byte-wide memory holding
// NUM_BLOCKS x 512 bytes. Used as a simulation model and as an on-FPGA
// virtual card.
//
// Ports:
//   clk, rst        system clock (>= 4x sd_sck), synchronous active-high reset
//   sd_sck          SPI clock from host (mode 0)
//   sd_cs           chip select from host, active low
//   sd_mosi         host-to-card serial data
//   sd_miso         card-to-host serial data, changes on SCK falling edges
//   mem_addr        byte address = block*512 + index
//   mem_rdata       read data, valid one clk after mem_addr
//   mem_wdata       write data
//   mem_we          one-clk write strobe
//   initialized     high once ACMD41 has completed
//   active          high while a CMD17/CMD24 data phase is in progress
// ---------------------------------------------------------------------------
module sdcard_spi_responder #(
    parameter int          NUM_BLOCKS = 1024,
    parameter int          ADDR_W     = 19,
    parameter int          BUSY_BYTES = 4,
    parameter logic [31:0] OCR        = 32'hC0FF8000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sd_sck,
    input  logic              sd_cs,
    input  logic              sd_mosi,
    output logic              sd_miso,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              initialized,
    output logic              active
);

    localparam int          BLK_W       = ADDR_W - 9;
    localparam logic [7:0]  BUSY_LAST   = 8'(BUSY_BYTES - 1);
    localparam logic [31:0] BLOCK_LIMIT = 32'(NUM_BLOCKS);

    typedef enum logic [3:0] {
        CMD_WAIT,
        CMD_ARG,
        CMD_CRC,
        NCR,
        RESP,
        RD_GAP,
        RD_TOKEN,
        RD_DATA,
        RD_CRC,
        WR_TOKEN,
        WR_DATA,
        WR_CRC,
        WR_DRESP,
        WR_BUSY
    } state_t;

    typedef enum logic [1:0] {
        KIND_NONE,
        KIND_READ,
        KIND_WRITE
    } kind_t;

    logic [1:0]       sck_sync;
    logic [1:0]       cs_sync;
    logic [1:0]       mosi_sync;
    logic             sck_prev;
    logic             sck_rise;
    logic             sck_fall;
    logic             cs_idle;

    state_t           state;
    kind_t            kind;
    logic [6:0]       rx_shift;
    logic [2:0]       rx_cnt;
    logic [7:0]       rx_byte;
    logic             rx_done;
    logic [7:0]       tx_shift;
    logic [2:0]       tx_cnt;
    logic             tx_load;
    logic [7:0]       tx_next;
    logic [5:0]       cmd_idx;
    logic [31:0]      cmd_arg;
    logic [1:0]       arg_cnt;
    logic [39:0]      resp_buf;
    logic [2:0]       resp_cnt;
    logic [BLK_W-1:0] blk;
    logic [8:0]       idx;
    logic [7:0]       aux_cnt;
    logic             app;

    logic             dec_init;
    logic             dec_app;
    logic             dec_illegal;
    logic             dec_param;
    kind_t            dec_kind;
    logic [2:0]       dec_len;
    logic [31:0]      dec_tail;
    logic [7:0]       dec_r1;

    // Bring the three SPI inputs into the clk domain. CS and MOSI idle high so
    // they reset to 1; SCK idles low in mode 0. sck_prev is one stage behind
    // the synchronised SCK so edges can be seen as a change between them.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b11;
            sck_prev  <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], sd_sck};
            cs_sync   <= {cs_sync[0], sd_cs};
            mosi_sync <= {mosi_sync[0], sd_mosi};
            sck_prev  <= sck_sync[1];
        end
    end

    assign sck_rise = sck_sync[1] & ~sck_prev;
    assign sck_fall = ~sck_sync[1] & sck_prev;
    assign cs_idle  = cs_sync[1];

    // A received byte completes on the 8th rising edge; the next transmit byte
    // is due on the 8th falling edge, half an SCK period later, so any state
    // change caused by the received byte is already in place by then.
    assign rx_byte  = {rx_shift, mosi_sync[1]};
    assign rx_done  = sck_rise & (rx_cnt == 3'd7);
    assign tx_load  = sck_fall & (tx_cnt == 3'd7);

    // Command decode, evaluated on the latched index/argument when the CRC
    // byte arrives. Produces the new flag values, the R1 byte, any trailing
    // response bytes (R7 echo or OCR) and whether a data phase follows.
    always_comb begin
        dec_init    = initialized;
        dec_app     = 1'b0;
        dec_illegal = 1'b0;
        dec_param   = 1'b0;
        dec_kind    = KIND_NONE;
        dec_len     = 3'd1;
        dec_tail    = 32'h0000_0000;
        case (cmd_idx)
            6'd0:  dec_init = 1'b0;
            6'd8: begin
                dec_len  = 3'd5;
                dec_tail = {16'h0000, 8'h01, cmd_arg[7:0]};
            end
            6'd16: ;
            6'd17, 6'd24: begin
                if (!initialized) begin
                    dec_illegal = 1'b1;
                end else if (cmd_arg >= BLOCK_LIMIT) begin
                    dec_param = 1'b1;
                end else begin
                    dec_kind = (cmd_idx == 6'd17) ? KIND_READ : KIND_WRITE;
                end
            end
            6'd41: begin
                if (app) begin
                    dec_init = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            6'd55: dec_app = 1'b1;
            6'd58: begin
                dec_len  = 3'd5;
                dec_tail = OCR;
            end
            default: dec_illegal = 1'b1;
        endcase
        dec_r1 = {1'b0, dec_param, 3'b000, dec_illegal, 1'b0, ~dec_init};
    end

    // Byte to start shifting at the next byte boundary. Anything that is not
    // an actual response, token or data byte goes out as the idle 0xFF.
    always_comb begin
        tx_next = 8'hFF;
        case (state)
            RESP:     tx_next = resp_buf[39:32];
            RD_TOKEN: tx_next = 8'hFE;
            RD_DATA:  tx_next = mem_rdata;
            WR_DRESP: tx_next = 8'h05;
            WR_BUSY:  tx_next = 8'h00;
            default:  tx_next = 8'hFF;
        endcase
    end

    // Main protocol engine. Receive-side events (rx_done) drive command
    // collection and write data; transmit-side events (tx_load) walk through
    // the response, read data and write status bytes. Both can never fire in
    // the same clk because they come from opposite SCK edges. Deselecting the
    // card abandons whatever was in progress but keeps the init flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= CMD_WAIT;
            kind        <= KIND_NONE;
            rx_shift    <= 7'h00;
            rx_cnt      <= 3'd0;
            tx_shift    <= 8'hFF;
            tx_cnt      <= 3'd0;
            cmd_idx     <= 6'd0;
            cmd_arg     <= 32'h0000_0000;
            arg_cnt     <= 2'd0;
            resp_buf    <= 40'hFF_FFFF_FFFF;
            resp_cnt    <= 3'd0;
            blk         <= '0;
            idx         <= 9'd0;
            aux_cnt     <= 8'd0;
            app         <= 1'b0;
            sd_miso     <= 1'b1;
            mem_addr    <= '0;
            mem_wdata   <= 8'h00;
            mem_we      <= 1'b0;
            initialized <= 1'b0;
            active      <= 1'b0;
        end else if (cs_idle) begin
            state    <= CMD_WAIT;
            rx_cnt   <= 3'd0;
            tx_cnt   <= 3'd0;
            tx_shift <= 8'hFF;
            sd_miso  <= 1'b1;
            mem_we   <= 1'b0;
            active   <= 1'b0;
        end else begin
            mem_we <= 1'b0;

            if (sck_rise) begin
                rx_shift <= rx_byte[6:0];
                rx_cnt   <= rx_cnt + 3'd1;
            end

            if (rx_done) begin
                case (state)
                    CMD_WAIT: begin
                        if (rx_byte[7:6] == 2'b01) begin
                            cmd_idx <= rx_byte[5:0];
                            arg_cnt <= 2'd0;
                            state   <= CMD_ARG;
                        end
                    end
                    CMD_ARG: begin
                        cmd_arg <= {cmd_arg[23:0], rx_byte};
                        arg_cnt <= arg_cnt + 2'd1;
                        if (arg_cnt == 2'd3) begin
                            state <= CMD_CRC;
                        end
                    end
                    CMD_CRC: begin
                        initialized <= dec_init;
                        app         <= dec_app;
                        resp_buf    <= {dec_r1, dec_tail};
                        resp_cnt    <= dec_len;
                        kind        <= dec_kind;
                        state       <= NCR;
                        if (dec_kind != KIND_NONE) begin
                            blk      <= cmd_arg[BLK_W-1:0];
                            mem_addr <= {cmd_arg[BLK_W-1:0], 9'd0};
                            idx      <= 9'd0;
                        end
                    end
                    WR_TOKEN: begin
                        if (rx_byte == 8'hFE) begin
                            state <= WR_DATA;
                        end
                    end
                    WR_DATA: begin
                        mem_we    <= 1'b1;
                        mem_wdata <= rx_byte;
                        mem_addr  <= {blk, idx};
                        idx       <= idx + 9'd1;
                        if (idx == 9'd511) begin
                            aux_cnt <= 8'd0;
                            state   <= WR_CRC;
                        end
                    end
                    WR_CRC: begin
                        aux_cnt <= aux_cnt + 8'd1;
                        if (aux_cnt == 8'd1) begin
                            state <= WR_DRESP;
                        end
                    end
                    default: ;
                endcase
            end

            if (sck_fall) begin
                tx_cnt <= tx_cnt + 3'd1;
                if (tx_load) begin
                    sd_miso  <= tx_next[7];
                    tx_shift <= {tx_next[6:0], 1'b1};
                end else begin
                    sd_miso  <= tx_shift[7];
                    tx_shift <= {tx_shift[6:0], 1'b1};
                end
            end

            if (tx_load) begin
                case (state)
                    NCR: state <= RESP;
                    RESP: begin
                        resp_buf <= {resp_buf[31:0], 8'hFF};
                        resp_cnt <= resp_cnt - 3'd1;
                        if (kind != KIND_NONE) begin
                            active <= 1'b1;
                        end
                        if (resp_cnt == 3'd1) begin
                            case (kind)
                                KIND_READ:  state <= RD_GAP;
                                KIND_WRITE: state <= WR_TOKEN;
                                default:    state <= CMD_WAIT;
                            endcase
                        end
                    end
                    RD_GAP:   state <= RD_TOKEN;
                    RD_TOKEN: state <= RD_DATA;
                    RD_DATA: begin
                        // The address for the following byte goes out now so
                        // its data is settled long before the next boundary.
                        idx <= idx + 9'd1;
                        if (idx == 9'd511) begin
                            aux_cnt <= 8'd0;
                            state   <= RD_CRC;
                        end else begin
                            mem_addr <= {blk, idx + 9'd1};
                        end
                    end
                    RD_CRC: begin
                        aux_cnt <= aux_cnt + 8'd1;
                        if (aux_cnt == 8'd1) begin
                            active <= 1'b0;
                            state  <= CMD_WAIT;
                        end
                    end
                    WR_DRESP: begin
                        aux_cnt <= 8'd0;
                        state   <= WR_BUSY;
                    end
                    WR_BUSY: begin
                        aux_cnt <= aux_cnt + 8'd1;
                        if (aux_cnt == BUSY_LAST) begin
                            active <= 1'b0;
                            state  <= CMD_WAIT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdcard_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_sdcard_spi_responder
//
// Directed bench for sdcard_spi_responder. Acts as the SD host (mode 0, SCK
// period 4 clk) and as the external byte memory. Unwritten memory reads back
// the low byte of its address, so block 3 naturally holds byte = index[7:0].
// ---------------------------------------------------------------------------
module tb_sdcard_spi_responder;

    localparam int ADDR_W = 19;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sd_sck = 1'b0;
    logic              sd_cs = 1'b1;
    logic              sd_mosi = 1'b1;
    logic              sd_miso;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              initialized;
    logic              active;

    int checks_total = 0;
    int checks_passed = 0;

    logic [7:0]        mem [0:524287];
    bit                written [0:524287];
    int                we_count = 0;
    int                wr_bad = 0;
    logic [ADDR_W-1:0] wr_min = '1;
    logic [ADDR_W-1:0] wr_max = '0;
    logic              rd_track = 1'b0;
    logic [ADDR_W-1:0] rd_min = '1;
    logic [ADDR_W-1:0] rd_max = '0;

    always #5 clk = ~clk;

    sdcard_spi_responder #(
        .NUM_BLOCKS(1024),
        .ADDR_W    (ADDR_W),
        .BUSY_BYTES(4),
        .OCR       (32'hC0FF8000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sd_sck     (sd_sck),
        .sd_cs      (sd_cs),
        .sd_mosi    (sd_mosi),
        .sd_miso    (sd_miso),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .initialized(initialized),
        .active     (active)
    );

    // Memory model plus traffic monitor: one-clk read latency, write strobes
    // counted with their address range, and the address range seen while a
    // tracked read data phase is active.
    always @(posedge clk) begin
        mem_rdata <= written[mem_addr] ? mem[mem_addr] : mem_addr[7:0];
        if (mem_we) begin
            mem[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
            we_count          <= we_count + 1;
            if (mem_wdata != 8'hA5) wr_bad <= wr_bad + 1;
            if (mem_addr < wr_min) wr_min <= mem_addr;
            if (mem_addr > wr_max) wr_max <= mem_addr;
        end
        if (rd_track && active) begin
            if (mem_addr < rd_min) rd_min <= mem_addr;
            if (mem_addr > rd_max) rd_max <= mem_addr;
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            checks_passed++;
        end
    endtask

    // One full-duplex SPI byte, mode 0. MISO is sampled just before each
    // falling edge, where it has been stable since the previous one.
    task automatic applyStimulus(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            sd_mosi = tx[i];
            #20 sd_sck = 1'b1;
            #20 rx[i] = sd_miso;
            sd_sck = 1'b0;
        end
        sd_mosi = 1'b1;
    endtask

    task automatic sendCommand(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
        logic [7:0] d;
        applyStimulus({2'b01, idx}, d);
        applyStimulus(arg[31:24], d);
        applyStimulus(arg[23:16], d);
        applyStimulus(arg[15:8], d);
        applyStimulus(arg[7:0], d);
        applyStimulus(crc, d);
    endtask

    task automatic readExpect(input string tag, input logic [7:0] exp);
        logic [7:0] b;
        applyStimulus(8'hFF, b);
        checkOutput(tag, {24'h0, b}, {24'h0, exp});
    endtask

    task automatic sendBytes(input logic [7:0] value, input int count);
        logic [7:0] d;
        for (int i = 0; i < count; i++) applyStimulus(value, d);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] rd_data [512];
        int         rd_err;
        int         act_err;
        int         we_before;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_miso",   {31'h0, sd_miso},     32'h1);
        checkOutput("rst_we",     {31'h0, mem_we},      32'h0);
        checkOutput("rst_addr",   {13'h0, mem_addr},    32'h0);
        checkOutput("rst_wdata",  {24'h0, mem_wdata},   32'h0);
        checkOutput("rst_init",   {31'h0, initialized}, 32'h0);
        checkOutput("rst_active", {31'h0, active},      32'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        #60 sd_cs = 1'b0;
        #60;

        $display("[TB] CMD0 and rejections before init");
        sendCommand(6'd0, 32'h0, 8'h95);
        readExpect("cmd0_ncr", 8'hFF);
        readExpect("cmd0_r1", 8'h01);
        checkOutput("cmd0_init", {31'h0, initialized}, 32'h0);

        we_before = we_count;
        sendCommand(6'd17, 32'h0, 8'hFF);
        readExpect("cmd17_noinit_ncr", 8'hFF);
        readExpect("cmd17_noinit_r1", 8'h05);
        sendCommand(6'd63, 32'h0, 8'hFF);
        readExpect("cmd63_noinit_r1", 8'hFF);
        readExpect("cmd63_noinit_r1b", 8'h05);
        checkOutput("noinit_no_we", we_count - we_before, 32'h0);
        checkOutput("noinit_addr", {13'h0, mem_addr}, 32'h0);
        checkOutput("noinit_active", {31'h0, active}, 32'h0);

        $display("[TB] CMD8, CMD41 without app, ACMD41, CMD58, CMD16");
        sendCommand(6'd8, 32'h0000_01AA, 8'h87);
        readExpect("cmd8_ncr", 8'hFF);
        readExpect("cmd8_r1", 8'h01);
        readExpect("cmd8_b1", 8'h00);
        readExpect("cmd8_b2", 8'h00);
        readExpect("cmd8_b3", 8'h01);
        readExpect("cmd8_b4", 8'hAA);
        sendCommand(6'd41, 32'h4000_0000, 8'hFF);
        readExpect("cmd41_noapp_ncr", 8'hFF);
        readExpect("cmd41_noapp_r1", 8'h05);
        checkOutput("cmd41_noapp_init", {31'h0, initialized}, 32'h0);
        sendCommand(6'd55, 32'h0, 8'hFF);
        readExpect("cmd55_ncr", 8'hFF);
        readExpect("cmd55_r1", 8'h01);
        sendCommand(6'd41, 32'h4000_0000, 8'hFF);
        readExpect("acmd41_ncr", 8'hFF);
        readExpect("acmd41_r1", 8'h00);
        checkOutput("acmd41_init", {31'h0, initialized}, 32'h1);
        sendCommand(6'd58, 32'h0, 8'hFF);
        readExpect("cmd58_ncr", 8'hFF);
        readExpect("cmd58_r1", 8'h00);
        readExpect("cmd58_ocr3", 8'hC0);
        readExpect("cmd58_ocr2", 8'hFF);
        readExpect("cmd58_ocr1", 8'h80);
        readExpect("cmd58_ocr0", 8'h00);
        sendCommand(6'd16, 32'd512, 8'hFF);
        readExpect("cmd16_ncr", 8'hFF);
        readExpect("cmd16_r1", 8'h00);

        $display("[TB] Rejections after init");
        we_before = we_count;
        sendCommand(6'd17, 32'd1024, 8'hFF);
        readExpect("cmd17_range_ncr", 8'hFF);
        readExpect("cmd17_range_r1", 8'h40);
        sendCommand(6'd63, 32'h0, 8'hFF);
        readExpect("cmd63_ncr", 8'hFF);
        readExpect("cmd63_r1", 8'h04);
        checkOutput("reject_no_we", we_count - we_before, 32'h0);
        checkOutput("reject_addr", {13'h0, mem_addr}, 32'h0);
        checkOutput("reject_active", {31'h0, active}, 32'h0);

        $display("[TB] CMD17 block 3");
        rd_track = 1'b1;
        sendCommand(6'd17, 32'd3, 8'hFF);
        readExpect("rd_ncr", 8'hFF);
        readExpect("rd_r1", 8'h00);
        checkOutput("rd_active_r1", {31'h0, active}, 32'h1);
        readExpect("rd_gap", 8'hFF);
        readExpect("rd_token", 8'hFE);
        rd_err = 0;
        act_err = 0;
        for (int i = 0; i < 512; i++) begin
            applyStimulus(8'hFF, rd_data[i]);
            if (rd_data[i] != 8'(i)) rd_err++;
            if (!active) act_err++;
        end
        checkOutput("rd_byte0", {24'h0, rd_data[0]}, 32'h00);
        checkOutput("rd_byte1", {24'h0, rd_data[1]}, 32'h01);
        checkOutput("rd_byte256", {24'h0, rd_data[256]}, 32'h00);
        checkOutput("rd_byte511", {24'h0, rd_data[511]}, 32'hFF);
        checkOutput("rd_data_errors", rd_err, 32'h0);
        checkOutput("rd_active_lapses", act_err, 32'h0);
        readExpect("rd_crc0", 8'hFF);
        readExpect("rd_crc1", 8'hFF);
        rd_track = 1'b0;
        checkOutput("rd_active_end", {31'h0, active}, 32'h0);
        checkOutput("rd_addr_min", {13'h0, rd_min}, 32'h600);
        checkOutput("rd_addr_max", {13'h0, rd_max}, 32'h7FF);
        readExpect("rd_idle", 8'hFF);

        $display("[TB] CMD24 block 5");
        we_before = we_count;
        sendCommand(6'd24, 32'd5, 8'hFF);
        readExpect("wr_ncr", 8'hFF);
        readExpect("wr_r1", 8'h00);
        checkOutput("wr_active_r1", {31'h0, active}, 32'h1);
        sendBytes(8'hFF, 1);
        sendBytes(8'hFE, 1);
        sendBytes(8'hA5, 512);
        sendBytes(8'h12, 1);
        sendBytes(8'h34, 1);
        checkOutput("wr_active_data", {31'h0, active}, 32'h1);
        readExpect("wr_dresp", 8'h05);
        readExpect("wr_busy0", 8'h00);
        readExpect("wr_busy1", 8'h00);
        readExpect("wr_busy2", 8'h00);
        readExpect("wr_busy3", 8'h00);
        readExpect("wr_idle", 8'hFF);
        checkOutput("wr_active_end", {31'h0, active}, 32'h0);
        checkOutput("wr_pulses", we_count - we_before, 32'd512);
        checkOutput("wr_addr_min", {13'h0, wr_min}, 32'hA00);
        checkOutput("wr_addr_max", {13'h0, wr_max}, 32'hBFF);
        checkOutput("wr_bad_data", wr_bad, 32'h0);

        $display("[TB] CS abort in the middle of CMD17");
        sendCommand(6'd17, 32'd3, 8'hFF);
        readExpect("abort_ncr", 8'hFF);
        readExpect("abort_r1", 8'h00);
        readExpect("abort_gap", 8'hFF);
        readExpect("abort_token", 8'hFE);
        for (int i = 0; i < 100; i++) applyStimulus(8'hFF, b);
        checkOutput("abort_last_byte", {24'h0, b}, 32'h63);
        #40;
        checkOutput("abort_miso_before", {31'h0, sd_miso}, 32'h0);
        sd_cs = 1'b1;
        #40;
        checkOutput("abort_miso_high", {31'h0, sd_miso}, 32'h1);
        checkOutput("abort_active", {31'h0, active}, 32'h0);
        checkOutput("abort_keeps_init", {31'h0, initialized}, 32'h1);
        #40 sd_cs = 1'b0;
        #60;
        sendCommand(6'd0, 32'h0, 8'h95);
        readExpect("abort_cmd0_ncr", 8'hFF);
        readExpect("abort_cmd0_r1", 8'h01);
        checkOutput("abort_cmd0_init", {31'h0, initialized}, 32'h0);

        $display("[TB] Reset in the middle of CMD24");
        sendCommand(6'd55, 32'h0, 8'hFF);
        readExpect("rst_cmd55_ncr", 8'hFF);
        readExpect("rst_cmd55_r1", 8'h01);
        sendCommand(6'd41, 32'h4000_0000, 8'hFF);
        readExpect("rst_acmd41_ncr", 8'hFF);
        readExpect("rst_acmd41_r1", 8'h00);
        we_before = we_count;
        sendCommand(6'd24, 32'd5, 8'hFF);
        readExpect("rst_wr_ncr", 8'hFF);
        readExpect("rst_wr_r1", 8'h00);
        sendBytes(8'hFE, 1);
        sendBytes(8'hA5, 10);
        #100;
        checkOutput("rst_wr_pulses", we_count - we_before, 32'd10);
        checkOutput("rst_wr_active", {31'h0, active}, 32'h1);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rstmid_init", {31'h0, initialized}, 32'h0);
        checkOutput("rstmid_we", {31'h0, mem_we}, 32'h0);
        checkOutput("rstmid_active", {31'h0, active}, 32'h0);
        checkOutput("rstmid_miso", {31'h0, sd_miso}, 32'h1);
        @(posedge clk);
        #2 rst = 1'b0;
        sd_cs = 1'b1;
        #40;

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/sdcard_spi_responder.md
Name: sdcard_spi_responder

Overview:
- SPI-mode SD card model: the card end of the link that our SD host controller drives.
- Used in simulation benches and as an on-FPGA "virtual card" for bring-up without physical media.
- Decodes 48-bit command frames and returns R1/R3/R7 responses.
- Serves single-block reads and writes (CMD17/CMD24) from an external byte-wide memory port holding NUM_BLOCKS × 512 bytes.

Parameters:
- NUM_BLOCKS, 1024, number of 512-byte blocks exposed; block addresses at or above this value are out of range.
- ADDR_W, 19, byte address width of the memory port; must equal log2(NUM_BLOCKS×512).
- BUSY_BYTES, 4, number of 0x00 busy bytes sent after a write's data response.
- OCR, 32'hC0FF8000, OCR value returned by CMD58 (power-up done, CCS=1).

Ports:
- clk  in  1  system clock; must be at least 4× sd_sck.
- rst  in  1  synchronous, active-high reset.
- sd_sck  in  1  SPI clock from host, mode 0.
- sd_cs  in  1  chip select from host, active low.
- sd_mosi  in  1  host-to-card data (host CMD line).
- sd_miso  out  1  card-to-host data (DAT0).
- mem_addr  out  ADDR_W  byte address = block×512 + index.
- mem_rdata  in  8  read data; valid 1 clk after mem_addr.
- mem_wdata  out  8  write data.
- mem_we  out  1  one-clk write strobe.
- initialized  out  1  high once ACMD41 has completed.
- active  out  1  high while a CMD17/CMD24 data phase is in progress.

Behaviour:
- **Synchronisation:** sd_sck, sd_cs and sd_mosi each pass through a 2-FF synchroniser. SCK rising and falling edges are detected in the clk domain.
- **SPI timing:** MOSI is sampled on SCK rising edges. MISO changes on SCK falling edges, MSB first. The next byte is loaded after the 8th falling edge, so its bit 7 is valid before the next rising edge.
- **Reset values:** sd_miso=1, mem_we=0, mem_addr=0, mem_wdata=0, initialized=0, active=0, state=CMD_WAIT, app flag=0.
- **Chip select high:** sd_miso=1, the bit counter clears, state returns to CMD_WAIT, mem_we=0. The initialized flag is kept. An aborted CMD24 leaves already-written bytes in memory.
- **MISO idle:** while no response byte is queued, MISO transmits 0xFF.
- **State CMD_WAIT:** byte-aligned receive. A byte matching 01xxxxxx starts a frame and its low 6 bits are the index. The next 4 bytes form arg (MSB first) and 1 byte is the CRC, which is ignored. Any other byte is discarded.
- **State NCR:** one 0xFF byte is sent, then RESP.
- **R1 coding:** bit0 = ~initialized; bit2 = illegal command; bit6 = parameter error.
- **Command set:**
  - CMD0: initialized:=0, app:=0, R1=0x01.
  - CMD8: R7 = R1, 0x00, 0x00, 0x01, arg[7:0].
  - CMD55: app:=1, R1.
  - ACMD41 (CMD41 with app=1): initialized:=1, R1=0x00.
  - CMD58: R1 followed by OCR, MSB byte first.
  - CMD16: R1 only.
  - Unknown index, or CMD41 without app: R1 with bit2 set.
  - app clears after any command other than CMD55.
- **Block-command rejection:** CMD17/CMD24 while not initialized → R1=0x05, no data phase. arg ≥ NUM_BLOCKS → R1=0x40, no data phase. arg is a block address.
- **CMD17 read:** R1=0x00, one 0xFF, token 0xFE, 512 data bytes from mem (index 0..511), then 0xFF 0xFF as CRC, then back to CMD_WAIT. Each data byte is prefetched: mem_addr for index n+1 is presented while byte n shifts.
- **CMD24 write:** R1=0x00, then the state waits for a received 0xFE token; non-token bytes are ignored. Each of the following 512 received bytes produces one mem_we pulse, with mem_wdata = that byte and mem_addr = base+index, within 2 clk of the byte completing. Two CRC bytes are then received and ignored. The card sends data response 0x05, then BUSY_BYTES × 0x00, then returns to CMD_WAIT.
- **active:** high from the R1 of an accepted CMD17/CMD24 until return to CMD_WAIT.
- **Index arithmetic:** the byte index is a 9-bit counter. Wrap from 511 ends the data phase. Block base = arg[ADDR_W-10:0] << 9.
- **Overlapping traffic:** bytes received while a response is being sent are ignored, except in the CMD24 data states. A new command start is recognised only in CMD_WAIT.

Test Plan:
- CMD0 (40 00 00 00 00 95) → MISO 0xFF, 0x01; initialized=0.
- CMD8 arg 0x1AA → 0xFF, 01 00 00 01 AA; then CMD55 + ACMD41 → R1 0x01, then 0x00; initialized=1; CMD58 → 00 C0 FF 80 00.
- Preload block 3 with byte value = index[7:0]; CMD17 arg 3 → 00, FF, FE, 00 01 .. FF 00 .. FF, FF FF; mem_addr spans 0x600..0x7FF; active high throughout the data phase.
- CMD24 arg 5, host sends FF FE + 512×0xA5 + 2 CRC bytes → 512 mem_we pulses at 0xA00..0xBFF, data 0xA5; MISO 0x05, then 4×0x00, then 0xFF.
- CMD17 before init → 0x05; CMD17 arg NUM_BLOCKS → 0x40; unknown CMD63 → bit2 set; no mem traffic in any case.
- CS deasserted mid-CMD17 at byte 100 → MISO=1 immediately, state CMD_WAIT; next CMD0 answered normally. rst asserted mid-CMD24 → initialized=0, mem_we=0 from the next clk.
